// File: rtl/deserializer.sv
// Assembles a contiguous burst of NUM_WORDS narrow words into one wide word,
// pulsing o_dv on completion and o_err when a burst ends early.
module deserializer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NUM_WORDS     = 4,
  parameter bit          LITTLE_ENDIAN = 1'b1
) (
  input  logic                       clk,
  input  logic                       i_reset,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_dv,
  output logic [NUM_WORDS*WIDTH-1:0] o_data,
  output logic                       o_dv,
  output logic                       o_err,
  output logic                       o_busy
);

  localparam int unsigned FRAME_W = NUM_WORDS * WIDTH;
  localparam int unsigned CNT_W   = $clog2(NUM_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  logic [FRAME_W-1:0] shift_q;
  logic [FRAME_W-1:0] assembled;
  logic [CNT_W-1:0]   count_q;

  // Shift register contents once the current i_data has been inserted.
  generate
    if (NUM_WORDS == 1) begin : g_single
      assign assembled = i_data;
    end else if (LITTLE_ENDIAN) begin : g_le
      assign assembled = {i_data, shift_q[FRAME_W-1:WIDTH]};
    end else begin : g_be
      assign assembled = {shift_q[FRAME_W-WIDTH-1:0], i_data};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_reset) begin
      shift_q <= '0;
      count_q <= '0;
      o_data  <= '0;
      o_dv    <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_dv  <= 1'b0;
      o_err <= 1'b0;
      if (i_dv) begin
        shift_q <= assembled;
        if (count_q == LAST_IDX) begin
          o_data  <= assembled;
          o_dv    <= 1'b1;
          count_q <= '0;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end else if (count_q != '0) begin
        // Burst ended early: drop the partial frame, keep the last good o_data.
        o_err   <= 1'b1;
        count_q <= '0;
        shift_q <= '0;
      end
    end
  end

  assign o_busy = (count_q != '0);

endmodule

// File: tb/tb_deserializer.sv
// Randomized self-checking bench for deserializer: LE and BE 4-word instances
// plus a single-word instance, all checked against a queue-based frame model.
module tb_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [7:0]  data_le, data_be;
  logic [31:0] le_data, be_data;
  logic        le_dv, le_err, le_busy, be_dv, be_err, be_busy;
  logic [7:0]  n1_data;
  logic        n1_dv, n1_err, n1_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  deserializer #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1'b1)) dut_le (
    .clk(clk), .i_reset(rst), .i_data(data_le), .i_dv(dv),
    .o_data(le_data), .o_dv(le_dv), .o_err(le_err), .o_busy(le_busy));

  deserializer #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1'b0)) dut_be (
    .clk(clk), .i_reset(rst), .i_data(data_be), .i_dv(dv),
    .o_data(be_data), .o_dv(be_dv), .o_err(be_err), .o_busy(be_busy));

  deserializer #(.WIDTH(8), .NUM_WORDS(1), .LITTLE_ENDIAN(1'b1)) dut_n1 (
    .clk(clk), .i_reset(rst), .i_data(data_le), .i_dv(dv),
    .o_data(n1_data), .o_dv(n1_dv), .o_err(n1_err), .o_busy(n1_busy));

  // Reference model state: words of the frame in progress, in arrival order.
  logic [7:0]  q_le[$];
  logic [7:0]  q_be[$];
  logic [31:0] exp_le_data, exp_be_data;
  logic [7:0]  exp_n1_data;
  logic        exp_dv, exp_err, exp_n1_dv;
  int          dv_pulses, err_pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] w[$], input bit le);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++)
      r = r | (32'(w[k]) << (le ? 8 * k : 8 * (3 - k)));
    return r;
  endfunction

  // Drive one cycle, advance the model across the edge, then compare all outputs.
  task automatic step(input logic r, input logic v, input logic [7:0] dle, input logic [7:0] dbe);
    rst = r; dv = v; data_le = dle; data_be = dbe;
    @(posedge clk);
    #1;
    exp_dv = 1'b0; exp_err = 1'b0; exp_n1_dv = 1'b0;
    if (r) begin
      q_le.delete(); q_be.delete();
      exp_le_data = '0; exp_be_data = '0; exp_n1_data = '0;
    end else if (v) begin
      q_le.push_back(dle); q_be.push_back(dbe);
      exp_n1_dv = 1'b1; exp_n1_data = dle;
      if (q_le.size() == 4) begin
        exp_le_data = pack(q_le, 1'b1);
        exp_be_data = pack(q_be, 1'b0);
        exp_dv = 1'b1;
        q_le.delete(); q_be.delete();
      end
    end else begin
      exp_err = (q_le.size() != 0);
      q_le.delete(); q_be.delete();
    end
    if (le_dv) dv_pulses++;
    if (le_err) err_pulses++;
    check("le_data", le_data, exp_le_data);
    check("le_dv",   32'(le_dv), 32'(exp_dv));
    check("le_err",  32'(le_err), 32'(exp_err));
    check("le_busy", 32'(le_busy), 32'(q_le.size() != 0));
    check("be_data", be_data, exp_be_data);
    check("be_dv",   32'(be_dv), 32'(exp_dv));
    check("be_err",  32'(be_err), 32'(exp_err));
    check("be_busy", 32'(be_busy), 32'(q_be.size() != 0));
    check("dv_err_excl", 32'(le_dv & le_err), 32'(0));
    check("n1_data", 32'(n1_data), 32'(exp_n1_data));
    check("n1_dv",   32'(n1_dv), 32'(exp_n1_dv));
    check("n1_err",  32'(n1_err), 32'(0));
    check("n1_busy", 32'(n1_busy), 32'(0));
  endtask

  task automatic word(input logic [7:0] d);
    step(1'b0, 1'b1, d, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  seq[8];
    int          p0, p1;
    exp_le_data = '0; exp_be_data = '0; exp_n1_data = '0;
    step(1'b1, 1'b1, 8'h5A, 8'h5A);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    check("rst_le_data", le_data, 32'h0);
    idle();

    // Basic frame, both endiannesses.
    word(8'h11); word(8'h22); word(8'h33); word(8'h44);
    check("frame_le", le_data, 32'h4433_2211);
    check("frame_be", be_data, 32'h1122_3344);
    check("frame_dv", 32'(le_dv & be_dv), 32'(1));
    idle();
    check("frame_dv_single", 32'(le_dv | be_dv), 32'(0));

    // Partial burst is flagged and discarded.
    word(8'hAA); word(8'hBB); idle();
    check("partial_err", 32'(le_err), 32'(1));
    check("partial_hold", le_data, 32'h4433_2211);
    idle();

    // Back-to-back frames.
    for (int i = 0; i < 8; i++) seq[i] = 8'(i + 1);
    p0 = dv_pulses; p1 = err_pulses;
    for (int i = 0; i < 8; i++) begin
      word(seq[i]);
      if (i == 3) check("b2b_first", le_data, 32'h0403_0201);
    end
    check("b2b_second", le_data, 32'h0807_0605);
    check("b2b_pulses", 32'(dv_pulses - p0), 32'(2));
    check("b2b_no_err", 32'(err_pulses - p1), 32'(0));
    idle();

    // Reset mid-frame drops the partial silently.
    word(8'h01); word(8'h02); word(8'h03);
    step(1'b1, 1'b1, 8'h04, 8'h04);
    check("midrst_data", le_data, 32'h0);
    check("midrst_err", 32'(le_err), 32'(0));
    idle();
    check("midrst_no_err", 32'(le_err), 32'(0));
    word(8'hDE); word(8'hAD); word(8'hBE); word(8'hEF);
    check("post_rst_frame", le_data, 32'hEFBE_ADDE);
    idle();

    // Loopback from a serializer model of matching endianness.
    p0 = dv_pulses; p1 = err_pulses;
    for (int f = 0; f < 100; f++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++)
        step(1'b0, 1'b1, w[8*k +: 8], w[8*(3-k) +: 8]);
      check("loop_le", le_data, w);
      check("loop_be", be_data, w);
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle();
    end
    check("loop_pulses", 32'(dv_pulses - p0), 32'(100));
    check("loop_errs", 32'(err_pulses - p1), 32'(0));

    // Random valid patterns including partial bursts and occasional reset.
    for (int c = 0; c < 600; c++)
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0,
           8'($urandom), 8'($urandom));
    idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
